ccsds_turbo_dec_rsc_chk: RTL and testbench

Receive-side companion of the CCSDS turbo RSC constituent encoder. Accepts hard-decision 4-bit symbols {s,1a,2a,3a} (MSB first) and recovers the systematic info bits. Re-encodes the recovered bits through an identical 4-register RSC and compares the regenerated parity and tail bits against the received ones. Reports per-frame mismatch count and termination validity; sits after the demodulator slicer and ahead of frame-quality monitoring.

---
 rtl/ccsds_turbo_dec_rsc_chk.sv | 145 ++++++++++++++
 tb/tb_ccsds_turbo_dec_rsc_chk.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccsds_turbo_dec_rsc_chk.sv
// Receive-side checker for the CCSDS turbo RSC constituent code.
// Recovers info bits from hard-decision symbols {s,1a,2a,3a}, re-encodes them through
// an identical 4-register RSC and counts parity/tail mismatches per frame.
// Optional macro CCSDS_RSC_CHK_SYMFLAG_EN adds the per-symbol mismatch vector o_sym_err.
module ccsds_turbo_dec_rsc_chk #(
  parameter int unsigned K     = 1784,
  parameter logic [4:0]  G1    = 5'b11011,
  parameter logic [4:0]  G2    = 5'b10101,
  parameter logic [4:0]  G3    = 5'b11111,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       i_data,
  input  logic             i_data_en,
  output logic             o_bit,
  output logic             o_bit_en,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_term_ok,
  output logic             o_frame_done
`ifdef CCSDS_RSC_CHK_SYMFLAG_EN
  ,
  output logic [3:0]       o_sym_err
`endif
);

  // Index must hold 0..K-1 and also the tail range 0..3.
  localparam int unsigned IdxW = ($clog2(K) > 2) ? $clog2(K) : 2;
  localparam int unsigned SumW = CNT_W + 3;

  typedef enum logic [1:0] {StIdle, StInfo, StTail} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [3:0]        rsc_q, rsc_d;
  logic              tail_ok_q, tail_ok_d;

  logic              s;
  logic              is_tail;
  logic              first;
  logic              fb;
  logic [4:0]        reg5;
  logic [2:0]        p_exp;
  logic [3:0]        mis_vec;
  logic [2:0]        mis_cnt;
  logic [SumW-1:0]   sum;
  logic [CNT_W-1:0]  err_d;
  logic              term_now;
  logic              frame_end;

  assign s = i_data[3];

  // Re-encode one symbol and form the mismatch vector against the received bits.
  always_comb begin
    is_tail = (state_q == StTail);
    first   = (state_q == StIdle);
    // In the tail the expected s equals the feedback term, so the mismatch reuses it.
    fb      = is_tail ? 1'b0 : (s ^ rsc_q[1] ^ rsc_q[0]);
    reg5    = {fb, rsc_q};
    p_exp   = {^(reg5 & G1), ^(reg5 & G2), ^(reg5 & G3)};
    mis_vec = {is_tail & (s ^ rsc_q[1] ^ rsc_q[0]), i_data[2:0] ^ p_exp};
    mis_cnt = {2'b00, mis_vec[3]} + {2'b00, mis_vec[2]} +
              {2'b00, mis_vec[1]} + {2'b00, mis_vec[0]};
  end

  // Saturating mismatch accumulator; the first symbol of a frame reloads it.
  always_comb begin
    sum   = (first ? '0 : SumW'(o_err_cnt)) + SumW'(mis_cnt);
    err_d = (|sum[SumW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Frame sequencing and RSC register update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rsc_d     = rsc_q;
    tail_ok_d = tail_ok_q;
    frame_end = 1'b0;
    term_now  = ((idx_q == '0) ? 1'b1 : tail_ok_q) & (mis_cnt == 3'd0);
    if (i_data_en) begin
      rsc_d = {fb, rsc_q[3:1]};
      if (is_tail) begin
        tail_ok_d = term_now;
        if (idx_q == IdxW'(3)) begin
          state_d   = StIdle;
          idx_d     = '0;
          rsc_d     = 4'b0000;
          frame_end = 1'b1;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end else if (idx_q == IdxW'(K - 1)) begin
        state_d = StTail;
        idx_d   = '0;
      end else begin
        state_d = StInfo;
        idx_d   = idx_q + IdxW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rsc_q     <= 4'b0000;
      tail_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rsc_q     <= rsc_d;
      tail_ok_q <= tail_ok_d;
    end
  end

  // Registered outputs, one cycle after the accepting edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_bit        <= 1'b0;
      o_bit_en     <= 1'b0;
      o_err_cnt    <= '0;
      o_term_ok    <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_bit_en     <= i_data_en & ~is_tail;
      o_frame_done <= frame_end;
      if (i_data_en && !is_tail) o_bit <= s;
      if (i_data_en) o_err_cnt <= err_d;
      if (frame_end) o_term_ok <= term_now;
    end
  end

`ifdef CCSDS_RSC_CHK_SYMFLAG_EN
  // Per-symbol mismatch flags, updated on every accepted symbol.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_sym_err <= 4'b0000;
    end else if (i_data_en) begin
      o_sym_err <= mis_vec;
    end
  end
`endif

endmodule

// File: tb/tb_ccsds_turbo_dec_rsc_chk.sv
// Scoreboard bench for ccsds_turbo_dec_rsc_chk with K=8: a 16-bit and a 2-bit counter
// instance see the same directed frames; a negedge monitor pops expected records.
module tb_ccsds_turbo_dec_rsc_chk;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  i_data;
  logic        i_data_en;
  logic        a_bit, a_bit_en, a_term_ok, a_done;
  logic [15:0] a_cnt;
  logic        s_bit, s_bit_en, s_term_ok, s_done;
  logic [1:0]  s_cnt;
`ifdef CCSDS_RSC_CHK_SYMFLAG_EN
  logic [3:0]  a_sym_err, s_sym_err;
`endif

  always #5 clk = ~clk;

  ccsds_turbo_dec_rsc_chk #(.K(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_data_en(i_data_en),
    .o_bit(a_bit), .o_bit_en(a_bit_en), .o_err_cnt(a_cnt),
    .o_term_ok(a_term_ok), .o_frame_done(a_done)
`ifdef CCSDS_RSC_CHK_SYMFLAG_EN
    , .o_sym_err(a_sym_err)
`endif
  );

  ccsds_turbo_dec_rsc_chk #(.K(8), .CNT_W(2)) dut_s (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_data_en(i_data_en),
    .o_bit(s_bit), .o_bit_en(s_bit_en), .o_err_cnt(s_cnt),
    .o_term_ok(s_term_ok), .o_frame_done(s_done)
`ifdef CCSDS_RSC_CHK_SYMFLAG_EN
    , .o_sym_err(s_sym_err)
`endif
  );

  typedef struct { int cyc; logic b; int cnt; int cnt_s; } bit_rec_t;
  typedef struct { int cyc; int cnt; int cnt_s; logic term; } done_rec_t;

  bit_rec_t  bq[$];
  done_rec_t dq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] syms [5][12];
  int         errs [5][12];
  logic       terms [5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pop and compare whenever either DUT presents an output.
  always @(negedge clk) begin
    bit_rec_t  br;
    done_rec_t dr;
    if (a_bit_en || s_bit_en) begin
      if (bq.size() == 0) begin
        check("unexpected_bit_en", 1, 0);
      end else begin
        br = bq.pop_front();
        check("bit_en_a", int'(a_bit_en), 1);
        check("bit_en_s", int'(s_bit_en), 1);
        check("bit_cycle", cyc, br.cyc);
        check("bit_a", int'(a_bit), int'(br.b));
        check("bit_s", int'(s_bit), int'(br.b));
        check("run_cnt_a", int'(a_cnt), br.cnt);
        check("run_cnt_s", int'(s_cnt), br.cnt_s);
      end
    end
    if (a_done || s_done) begin
      if (dq.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        dr = dq.pop_front();
        check("done_a", int'(a_done), 1);
        check("done_s", int'(s_done), 1);
        check("done_cycle", cyc, dr.cyc);
        check("frame_cnt_a", int'(a_cnt), dr.cnt);
        check("frame_cnt_s", int'(s_cnt), dr.cnt_s);
        check("term_ok_a", int'(a_term_ok), int'(dr.term));
        check("term_ok_s", int'(s_term_ok), int'(dr.term));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_bit", int'(a_bit | s_bit), 0);
    check("rst_bit_en", int'(a_bit_en | s_bit_en), 0);
    check("rst_cnt_a", int'(a_cnt), 0);
    check("rst_cnt_s", int'(s_cnt), 0);
    check("rst_term_ok", int'(a_term_ok | s_term_ok), 0);
    check("rst_done", int'(a_done | s_done), 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      i_data_en = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sym(input logic [3:0] d);
    i_data    = d;
    i_data_en = 1'b1;
    @(posedge clk);
    #1;
    i_data_en = 1'b0;
  endtask

  // Sends frame f; stops before symbol stop_at when stop_at >= 0.
  task automatic send_frame(input int f, input int gap_every, input int stop_at);
    int run;
    int rs;
    logic [3:0] sym;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      sym = syms[f][i];
      run = (i == 0) ? errs[f][i] : run + errs[f][i];
      rs  = (run > 3) ? 3 : run;
      if (i < 8) bq.push_back('{cyc: cyc + 1, b: sym[3], cnt: run, cnt_s: rs});
      if (i == 11) dq.push_back('{cyc: cyc + 1, cnt: run, cnt_s: rs, term: terms[f]});
      drive_sym(sym);
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) idle(1);
    end
  endtask

  initial begin
    // 0: all zero. 1: info 1,0,... correctly encoded. 2: sym0 2a flipped.
    // 3: tail2 s inverted. 4: five info-parity 3a flips (idx 1..5).
    for (int i = 0; i < 12; i++) begin
      syms[0][i] = 4'b0000;
      for (int f = 0; f < 5; f++) errs[f][i] = 0;
    end
    syms[1] = '{4'b1111, 4'b0101, 4'b0011, 4'b0010, 4'b0101, 4'b0110, 4'b0001, 4'b0111,
                4'b1100, 4'b1101, 4'b1111, 4'b0000};
    syms[2] = syms[1];
    syms[2][0] = 4'b1101;
    errs[2][0] = 1;
    syms[3] = syms[1];
    syms[3][10] = 4'b0111;
    errs[3][10] = 1;
    syms[4] = syms[1];
    syms[4][1] = 4'b0100;
    syms[4][2] = 4'b0010;
    syms[4][3] = 4'b0011;
    syms[4][4] = 4'b0100;
    syms[4][5] = 4'b0111;
    for (int i = 1; i <= 5; i++) errs[4][i] = 1;
    terms = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rstn      = 1'b0;
    i_data    = 4'b0000;
    i_data_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    send_frame(0, 0, -1);
    send_frame(0, 3, -1);
    send_frame(1, 0, -1);
    send_frame(2, 0, -1);
    send_frame(3, 5, -1);
    send_frame(4, 0, -1);
    send_frame(1, 0, -1);
    // Abandon a gapped frame at info index 4.
    send_frame(1, 1, 4);
    idle(2);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    send_frame(1, 0, -1);
    idle(5);

    check("bit_queue_left", bq.size(), 0);
    check("done_queue_left", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
